data_memory_be: RTL and testbench
=================================

DATA_MEMORY_BE -- requirements
Module: data_memory_be

Interface
REQ-001 Parameter ADDR_W, default 12, byte-address width; the array holds 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter DATA_W, default 32, data width; only 32 is supported, and elaboration shall fail for any other value.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 REQ  in  1  access request; accepted when REQ && READY at a rising edge.
REQ-006 W_EN  in  1  1 = store, 0 = load.
REQ-007 SIZE  in  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 UNS  in  1  load zero-extends when 1 and sign-extends when 0; ignored for stores and word loads.
REQ-009 ADDR  in  ADDR_W  byte address.
REQ-010 D_IN  in  32  store data, right-justified for byte and halfword stores.
REQ-011 READY  out  1  block can accept a request this cycle.
REQ-012 VALID  out  1  one-cycle pulse qualifying D_OUT for a completed load.
REQ-013 D_OUT  out  32  load result, extended per SIZE and UNS.
REQ-014 MISALIGN  out  1  one-cycle pulse flagging a rejected misaligned access.

Function
REQ-015 Byte order is big-endian: byte lane ADDR[1:0]=0 is bits 31:24, and halfword ADDR[1]=0 is bits 31:16.
REQ-016 Word index is ADDR[ADDR_W-1:2].
REQ-017 Misaligned means SIZE=01 with ADDR[0]=1, or a word access with ADDR[1:0]!=0.
REQ-018 A misaligned access does not touch the array, pulses MISALIGN the cycle after acceptance, and takes one cycle.
REQ-019 A misaligned load also pulses VALID in the same cycle as MISALIGN, with D_OUT=0.
REQ-020 FSM has two states, IDLE and MERGE; READY=1 exactly in IDLE.
REQ-021 A load accepted in IDLE returns D_OUT with VALID=1 on the next cycle (latency 1); the FSM stays IDLE.
REQ-022 A word store accepted in IDLE writes the array at that edge; the FSM stays IDLE.
REQ-023 A byte or halfword store uses read-modify-write.
REQ-024 RMW acceptance edge: capture the addressed word, shifted D_IN lanes and lane mask; go to MERGE.
REQ-025 RMW MERGE edge: write the merged word (unselected lanes unchanged); return to IDLE.
REQ-026 A sub-word store therefore occupies 2 cycles, with READY low for 1 cycle.
REQ-027 REQ while READY=0 is ignored; the requester must hold the request.
REQ-028 A load accepted the cycle after any store completes returns the newly written data.
REQ-029 VALID is 0 for stores and in every cycle without a completed load.
REQ-030 D_OUT holds its last value when VALID=0.
REQ-031 Address wrap: none; every ADDR value maps to a unique word.

Reset
REQ-032 rst=1 at an edge forces state=IDLE, READY=1, VALID=0, MISALIGN=0, D_OUT=0.
REQ-033 Reset in MERGE abandons the store, leaving that word unchanged.
REQ-034 Reset of an in-flight load suppresses its VALID pulse.
REQ-035 Array contents are not reset.
REQ-036 rst has priority over REQ.

Configuration
REQ-037 Macro DMEM_OUTREG_EN, when defined, adds an output register stage.
REQ-038 With DMEM_OUTREG_EN: load and misalign latency becomes 2 cycles; VALID, MISALIGN and D_OUT are delayed together; the extra stage resets to 0.
REQ-039 Without DMEM_OUTREG_EN: latency is 1 cycle; READY and store timing are identical in both builds.

Structure
REQ-040 Package dmem_pkg holds: enum mem_size_t (SZ_BYTE, SZ_HALF, SZ_WORD), enum dmem_state_t (IDLE, MERGE), and constant DMEM_WORD_W=32.
REQ-041 Sub-module dmem_load_align is purely combinational: lane select plus sign/zero extension from word, ADDR[1:0], SIZE and UNS.

Verification
REQ-042 Word store 0xDEADBEEF @0x010, then load word @0x010 -> VALID next cycle, D_OUT=0xDEADBEEF.
REQ-043 Byte store 0x000000AB @0x012 over 0x11223344 -> READY low 1 cycle; word load returns 0x1122AB44; lb @0x012 returns 0xFFFFFFAB; lbu returns 0x000000AB.
REQ-044 Halfword load @0x011 -> MISALIGN=1, VALID=1, D_OUT=0; a word store @0x006 -> MISALIGN=1 and memory unchanged.
REQ-045 Back-to-back: sh 0x8001 @0x020, then lh @0x020 held while READY=0 -> accepted after MERGE; returns 0xFFFF8001.
REQ-046 Assert rst in MERGE of sb @0x030 -> READY=1 and VALID=0 next cycle; word @0x030 is unchanged.
REQ-047 With DMEM_OUTREG_EN, rerun REQ-042 -> VALID 2 cycles after acceptance, same data.

Source files
------------

// File: rtl/data_memory_be_pkg.sv
// Shared types and lane helpers for the big-endian byte-enabled data memory.
// Lane 0 (ADDR[1:0]=0) is the most significant byte of a word.
package dmem_pkg;

  localparam int DMEM_WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_t;

  typedef enum logic {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } dmem_state_t;

  function automatic mem_size_t decode_size(input logic [1:0] s);
    unique case (s)
      2'b00:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(
    input mem_size_t sz,
    input logic [1:0] lo
  );
    unique case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(
    input mem_size_t sz,
    input logic [1:0] lo
  );
    unique case (sz)
      SZ_BYTE: return 4'b1000 >> lo;
      SZ_HALF: return lo[1] ? 4'b0011 : 4'b1100;
      default: return 4'b1111;
    endcase
  endfunction

  // ~lo equals 3-lo, so the shift moves byte 0 to the top lane
  function automatic logic [31:0] lane_data(
    input mem_size_t sz,
    input logic [1:0] lo,
    input logic [31:0] d
  );
    unique case (sz)
      SZ_BYTE: return {24'b0, d[7:0]} << {~lo, 3'b000};
      SZ_HALF: return lo[1] ? {16'b0, d[15:0]}
                            : {d[15:0], 16'b0};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] mask_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

endpackage

// File: rtl/data_memory_be_if.sv
// Request/response bundle of the data memory.
// The master drives requests, the slave answers.
interface data_memory_be_if #(
  parameter int ADDR_W = 12
);
  logic              REQ;
  logic              W_EN;
  logic [1:0]        SIZE;
  logic              UNS;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       D_IN;
  logic              READY;
  logic              VALID;
  logic [31:0]       D_OUT;
  logic              MISALIGN;

  modport master (
    output REQ, W_EN, SIZE, UNS, ADDR, D_IN,
    input  READY, VALID, D_OUT, MISALIGN
  );

  modport slave (
    input  REQ, W_EN, SIZE, UNS, ADDR, D_IN,
    output READY, VALID, D_OUT, MISALIGN
  );
endinterface

// File: rtl/data_memory_be_load_align.sv
// Combinational load lane select with sign/zero extension.
// Big-endian: lane 0 is bits 31:24, half 0 is bits 31:16.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  mem_size_t   size,
  input  logic        uns,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b    = 8'(word >> {~lo, 3'b000});
    h    = lo[1] ? word[15:0] : word[31:16];
    data = word;
    unique case (size)
      SZ_BYTE: data = {{24{~uns & b[7]}}, b};
      SZ_HALF: data = {{16{~uns & h[15]}}, h};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/data_memory_be.sv
// Big-endian data memory with byte/half read-modify-write stores.
// Define DMEM_OUTREG_EN to add one output register stage on loads.
module data_memory_be
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst,
  data_memory_be_if.slave bus
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);

  if (DATA_W != DMEM_WORD_W) begin : g_bad_width
    $error("data_memory_be supports DATA_W=32 only");
  end

  logic [DMEM_WORD_W-1:0] mem [DEPTH];

  dmem_state_t       state, state_nx;
  mem_size_t         sz;
  logic [1:0]        lo;
  logic [ADDR_W-3:0] idx;
  logic              acc, mis, word_wr, rmw_go;
  logic [31:0]       rd_word, ld_data;

  logic [ADDR_W-3:0] m_idx;
  logic [31:0]       m_word, m_data, m_mask;

  logic              v_q, mis_q;
  logic [31:0]       d_q;

  assign sz      = decode_size(bus.SIZE);
  assign lo      = bus.ADDR[1:0];
  assign idx     = bus.ADDR[ADDR_W-1:2];
  assign rd_word = mem[idx];
  assign mis     = is_misaligned(sz, lo);

  assign bus.READY = (state == IDLE);

  dmem_load_align u_align (
    .word (rd_word),
    .lo   (lo),
    .size (sz),
    .uns  (bus.UNS),
    .data (ld_data)
  );

  always_comb begin
    state_nx = state;
    acc      = 1'b0;
    word_wr  = 1'b0;
    rmw_go   = 1'b0;
    unique case (state)
      IDLE: begin
        acc = bus.REQ;
        if (acc && bus.W_EN && !mis) begin
          if (sz == SZ_WORD) begin
            word_wr = 1'b1;
          end else begin
            rmw_go   = 1'b1;
            state_nx = MERGE;
          end
        end
      end
      MERGE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rmw_go) begin
      m_idx  <= idx;
      m_word <= rd_word;
      m_data <= lane_data(sz, lo, bus.D_IN);
      m_mask <= mask_bits(lane_mask(sz, lo));
    end
  end

  // rst gates the write so a reset in MERGE drops the store
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (word_wr)
        mem[idx] <= bus.D_IN;
      else if (state == MERGE)
        mem[m_idx] <= (m_word & ~m_mask) | (m_data & m_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= 1'b0;
      mis_q <= 1'b0;
      d_q   <= '0;
    end else begin
      v_q   <= acc && !bus.W_EN;
      mis_q <= acc && mis;
      if (acc && !bus.W_EN)
        d_q <= mis ? '0 : ld_data;
    end
  end

`ifdef DMEM_OUTREG_EN
  logic        v_q2, mis_q2;
  logic [31:0] d_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q2   <= 1'b0;
      mis_q2 <= 1'b0;
      d_q2   <= '0;
    end else begin
      v_q2   <= v_q;
      mis_q2 <= mis_q;
      d_q2   <= d_q;
    end
  end

  assign bus.VALID    = v_q2;
  assign bus.MISALIGN = mis_q2;
  assign bus.D_OUT    = d_q2;
`else
  assign bus.VALID    = v_q;
  assign bus.MISALIGN = mis_q;
  assign bus.D_OUT    = d_q;
`endif

endmodule

// File: tb/tb_data_memory_be.sv
// Scoreboard bench for data_memory_be; expected pulses are queued at
// issue time and popped by a monitor when VALID/MISALIGN fire.
module tb_data_memory_be;

`ifdef DMEM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_memory_be_if #(.ADDR_W(12)) bus ();

  data_memory_be #(
    .ADDR_W (12),
    .DATA_W (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          cyc;
    logic        valid;
    logic        mis;
    logic [31:0] d;
    logic        chk_d;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst === 1'b0 && (bus.VALID === 1'b1 || bus.MISALIGN === 1'b1)) begin
      vectors++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse got valid=%b mis=%b d=%h",
                 bus.VALID, bus.MISALIGN, bus.D_OUT);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (bus.VALID !== e.valid || bus.MISALIGN !== e.mis ||
            (e.chk_d && bus.D_OUT !== e.d) || cyc != e.cyc) begin
          errors++;
          $display("FAIL %s got v=%b m=%b d=%h cyc=%0d required v=%b m=%b d=%h cyc=%0d",
                   e.tag, bus.VALID, bus.MISALIGN, bus.D_OUT, cyc,
                   e.valid, e.mis, e.d, e.cyc);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [1:0] s, input logic u,
                       input logic [11:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input string tag,
                       output int waits);
    logic misal;
    exp_t e;
    misal = (s == 2'b01 && a[0]) || (s[1] && a[1:0] != 2'b00);
    bus.REQ  = 1'b1;
    bus.W_EN = w;
    bus.SIZE = s;
    bus.UNS  = u;
    bus.ADDR = a;
    bus.D_IN = d;
    waits = 0;
    while (bus.READY !== 1'b1 && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 8) begin
      vectors++;
      errors++;
      $display("FAIL %s_accept got ready=%b required ready=1", tag, bus.READY);
      bus.REQ = 1'b0;
      return;
    end
    if (!w || misal) begin
      e.cyc   = cyc + LAT;
      e.valid = !w;
      e.mis   = misal;
      e.d     = misal ? 32'h0 : exp_d;
      e.chk_d = !w;
      e.tag   = tag;
      sbq.push_back(e);
    end
    @(negedge clk);
    bus.REQ = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL missing_pulse got %0d outstanding required 0", sbq.size());
      sbq.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.READY !== 1'b1 || bus.VALID !== 1'b0 ||
        bus.MISALIGN !== 1'b0 || bus.D_OUT !== 32'h0) begin
      errors++;
      $display("FAIL reset_state got r=%b v=%b m=%b d=%h required 1 0 0 00000000",
               bus.READY, bus.VALID, bus.MISALIGN, bus.D_OUT);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    int w;
    issue(1, 2'b10, 0, 12'h010, 32'hDEADBEEF, 0, "sw", w);
    issue(0, 2'b10, 0, 12'h010, 0, 32'hDEADBEEF, "lw_010", w);
    drain();
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.VALID !== 1'b0 || bus.D_OUT !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL dout_hold got v=%b d=%h required v=0 d=deadbeef",
               bus.VALID, bus.D_OUT);
    end
  endtask

  task automatic test_byte_rmw();
    int w;
    issue(1, 2'b10, 0, 12'h010, 32'h11223344, 0, "sw", w);
    issue(1, 2'b00, 0, 12'h012, 32'h000000AB, 0, "sb", w);
    issue(0, 2'b10, 0, 12'h010, 0, 32'h1122AB44, "lw_after_sb", w);
    vectors++;
    if (w != 1) begin
      errors++;
      $display("FAIL sb_ready_low got %0d cycles required 1", w);
    end
    issue(0, 2'b00, 0, 12'h012, 0, 32'hFFFFFFAB, "lb_012", w);
    issue(0, 2'b00, 1, 12'h012, 0, 32'h000000AB, "lbu_012", w);
    drain();
  endtask

  task automatic test_lanes();
    int w;
    logic [7:0] by [4];
    logic [31:0] ex;
    by[0] = 8'h88; by[1] = 8'h99; by[2] = 8'hAA; by[3] = 8'hBB;
    issue(1, 2'b10, 0, 12'h040, 32'h8899AABB, 0, "sw", w);
    for (int i = 0; i < 4; i++) begin
      for (int u = 0; u < 2; u++) begin
        ex = {{24{(u == 0) & by[i][7]}}, by[i]};
        issue(0, 2'b00, 1'(u), 12'h040 + 12'(i), 0, ex, $sformatf("lb_lane%0d_u%0d", i, u), w);
      end
    end
    issue(0, 2'b01, 0, 12'h040, 0, 32'hFFFF8899, "lh_lo0", w);
    issue(0, 2'b01, 1, 12'h042, 0, 32'h0000AABB, "lhu_lo2", w);
    issue(0, 2'b11, 1, 12'h040, 0, 32'h8899AABB, "lw_size3", w);
    issue(1, 2'b01, 0, 12'h042, 32'hFFFF1234, 0, "sh", w);
    issue(0, 2'b10, 0, 12'h040, 0, 32'h88991234, "lw_after_sh", w);
    issue(1, 2'b10, 0, 12'h044, 32'h0, 0, "sw", w);
    issue(1, 2'b00, 0, 12'h044, 32'h1234565A, 0, "sb", w);
    issue(0, 2'b10, 0, 12'h044, 0, 32'h5A000000, "lw_lane0", w);
    drain();
  endtask

  task automatic test_misalign();
    int w;
    issue(0, 2'b01, 0, 12'h011, 0, 0, "lh_011_mis", w);
    issue(1, 2'b10, 0, 12'h004, 32'h0BADF00D, 0, "sw", w);
    issue(1, 2'b10, 0, 12'h006, 32'hFFFFFFFF, 0, "sw_006_mis", w);
    vectors++;
    if (bus.READY !== 1'b1) begin
      errors++;
      $display("FAIL mis_ready got %b required 1", bus.READY);
    end
    issue(1, 2'b01, 0, 12'h005, 32'h0000FFFF, 0, "sh_005_mis", w);
    issue(0, 2'b10, 0, 12'h004, 0, 32'h0BADF00D, "lw_004_unchanged", w);
    issue(0, 2'b10, 0, 12'h002, 0, 0, "lw_002_mis", w);
    drain();
  endtask

  task automatic test_back_to_back();
    int w;
    issue(1, 2'b01, 0, 12'h020, 32'h00008001, 0, "sh", w);
    issue(0, 2'b01, 0, 12'h020, 0, 32'hFFFF8001, "lh_020_held", w);
    vectors++;
    if (w != 1) begin
      errors++;
      $display("FAIL lh_held_wait got %0d cycles required 1", w);
    end
    drain();
  endtask

  task automatic test_reset_merge();
    int w;
    issue(1, 2'b10, 0, 12'h030, 32'hCAFEF00D, 0, "sw", w);
    issue(1, 2'b00, 0, 12'h030, 32'h00000077, 0, "sb", w);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (bus.READY !== 1'b1 || bus.VALID !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_merge got r=%b v=%b required r=1 v=0",
               bus.READY, bus.VALID);
    end
    issue(0, 2'b10, 0, 12'h030, 0, 32'hCAFEF00D, "lw_030_unchanged", w);
    drain();
  endtask

  task automatic test_edges();
    int w;
    issue(1, 2'b10, 0, 12'hFFC, 32'h13579BDF, 0, "sw", w);
    issue(1, 2'b10, 0, 12'h000, 32'h2468ACE0, 0, "sw", w);
    issue(0, 2'b10, 0, 12'hFFC, 0, 32'h13579BDF, "lw_top", w);
    issue(0, 2'b10, 0, 12'h000, 0, 32'h2468ACE0, "lw_zero", w);
    issue(0, 2'b00, 1, 12'hFFF, 0, 32'h000000DF, "lbu_top", w);
    drain();
  endtask

  initial begin
    bus.REQ  = 1'b0;
    bus.W_EN = 1'b0;
    bus.SIZE = 2'b00;
    bus.UNS  = 1'b0;
    bus.ADDR = '0;
    bus.D_IN = '0;
    rst      = 1'b1;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte_rmw();
    test_lanes();
    test_misalign();
    test_back_to_back();
    test_reset_merge();
    test_edges();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
